// File: rtl/ahb_wr_capture_if.sv
// ahb_wr_capture_if
//  Groups the snooped AHB-Lite master signals and the capture FIFO's valid/ready
//  consumer port into a single bundle.
//  Signals:
//   htrans/hwrite/hsize/haddr/hwdata/hready : AHB-Lite master bus (snooped)
//   wr_vld/wr_addr/wr_data                  : FIFO head entry toward the decoder
//   wr_rdy                                  : decoder ready (pop on wr_vld && wr_rdy)
//  Modports:
//   master : environment side (drives the bus and wr_rdy, observes the FIFO head)
//   slave  : capture block side
interface ahb_wr_capture_if;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hready;
   logic        wr_vld;
   logic [15:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_rdy;

   modport master (
      output htrans, hwrite, hsize, haddr, hwdata, hready, wr_rdy,
      input  wr_vld, wr_addr, wr_data
   );

   modport slave (
      input  htrans, hwrite, hsize, haddr, hwdata, hready, wr_rdy,
      output wr_vld, wr_addr, wr_data
   );
endinterface

// File: rtl/ahb_wr_capture.sv
// ahb_wr_capture
//  Snoops the CPU AHB-Lite master bus and captures 32-bit writes that hit the
//  capture window. Each accepted address phase is paired with its data phase and
//  {offset, data} is pushed into a first-word-fall-through FIFO that feeds the
//  decoder through a valid/ready port. Single clock domain.
//  Ports:
//   I_clk        : CPU clock
//   I_rst        : synchronous reset, active-high
//   bus          : ahb_wr_capture_if.slave (AHB snoop inputs, FIFO head/ready)
//   O_fifo_lvl   : FIFO occupancy, 0..2**FIFO_AW
//   O_ovf        : sticky, at least one capture dropped since reset
//   O_ovf_cnt    : dropped-capture count, saturating
//   O_wr_tstamp  : head entry timestamp (only with AHB_CAP_TSTAMP_EN)
//  Build option:
//   AHB_CAP_TSTAMP_EN : adds a free-running cycle counter sampled at data-phase
//                       completion and stored with each entry (80-bit entries).
module ahb_wr_capture #(
   parameter logic [31:0] ADDR_BASE = 32'h4000_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
   parameter int unsigned FIFO_AW   = 4
) (
   input  logic                 I_clk,
   input  logic                 I_rst,
   ahb_wr_capture_if.slave      bus,
   output logic [FIFO_AW:0]     O_fifo_lvl,
   output logic                 O_ovf,
   output logic [15:0]          O_ovf_cnt
`ifdef AHB_CAP_TSTAMP_EN
   ,
   output logic [31:0]          O_wr_tstamp
`endif
);

   localparam int unsigned DEPTH = 2 ** FIFO_AW;
`ifdef AHB_CAP_TSTAMP_EN
   localparam int unsigned FW = 80;
`else
   localparam int unsigned FW = 48;
`endif

   // Address/data phase pairing
   logic              pend_q, pend_d;
   logic [15:0]       pend_addr_q, pend_addr_d;
   logic              accept;
   logic              push;
   logic [FW-1:0]     push_entry;

   // FIFO storage and pointers (extra MSB distinguishes full from empty)
   logic [FW-1:0]     mem [DEPTH];
   logic [FIFO_AW:0]  wr_ptr_q, rd_ptr_q;
   logic              empty, full, pop, push_ok, drop;
   logic [FW-1:0]     head;

   logic              ovf_q;
   logic [15:0]       ovf_cnt_q;

`ifdef AHB_CAP_TSTAMP_EN
   logic [31:0]       tstamp_q;
`endif

   // Only NONSEQ/SEQ word writes inside the window start a capture.
   assign accept = bus.hready
                 && ((bus.htrans == 2'b10) || (bus.htrans == 2'b11))
                 && bus.hwrite
                 && (bus.hsize == 3'b010)
                 && ((bus.haddr & ADDR_MASK) == ADDR_BASE);

   // Data phase completes on the first ready cycle after an accepted address.
   assign push = pend_q && bus.hready;

`ifdef AHB_CAP_TSTAMP_EN
   assign push_entry = {tstamp_q, pend_addr_q, bus.hwdata};
`else
   assign push_entry = {pend_addr_q, bus.hwdata};
`endif

   always_comb begin
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      // During wait states the pending phase is simply held.
      if (bus.hready) begin
         pend_d = accept;
         if (accept) begin
            pend_addr_d = bus.haddr[15:0] - ADDR_BASE[15:0];
         end
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         pend_q      <= 1'b0;
         pend_addr_q <= 16'h0000;
      end else begin
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
      end
   end

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW])
                 && (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign pop     = !empty && bus.wr_rdy;
   // A pop in the same cycle frees the slot the push needs.
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   always_ff @(posedge I_clk) begin
      if (push_ok) begin
         mem[wr_ptr_q[FIFO_AW-1:0]] <= push_entry;
      end
   end

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ovf_q     <= 1'b0;
         ovf_cnt_q <= 16'h0000;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (drop) begin
            ovf_q <= 1'b1;
            if (ovf_cnt_q != 16'hFFFF) begin
               ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
         end
      end
   end

`ifdef AHB_CAP_TSTAMP_EN
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         tstamp_q <= 32'h0000_0000;
      end else begin
         tstamp_q <= tstamp_q + 32'd1;
      end
   end
`endif

   // Head is read straight from the registered storage; outputs are forced to
   // zero while empty so reset and idle show clean values.
   assign head = mem[rd_ptr_q[FIFO_AW-1:0]];

   always_comb begin
      bus.wr_vld  = !empty;
      bus.wr_addr = 16'h0000;
      bus.wr_data = 32'h0000_0000;
`ifdef AHB_CAP_TSTAMP_EN
      O_wr_tstamp = 32'h0000_0000;
`endif
      if (!empty) begin
         bus.wr_addr = head[47:32];
         bus.wr_data = head[31:0];
`ifdef AHB_CAP_TSTAMP_EN
         O_wr_tstamp = head[79:48];
`endif
      end
   end

   assign O_fifo_lvl = wr_ptr_q - rd_ptr_q;
   assign O_ovf      = ovf_q;
   assign O_ovf_cnt  = ovf_cnt_q;

endmodule

// File: tb/tb_ahb_wr_capture.sv
// tb_ahb_wr_capture
//  Self-checking bench for ahb_wr_capture: a vector table of single transfers
//  plus hand-written burst, overflow, full-throughput and reset sequences.
//  Expected entries go into a scoreboard queue when the data phase is driven and
//  are compared whenever the FIFO head is popped.
module tb_ahb_wr_capture;

   logic        clk;
   logic        rst;
   logic [4:0]  lvl;
   logic        ovf;
   logic [15:0] ovf_cnt;
`ifdef AHB_CAP_TSTAMP_EN
   logic [31:0] tstamp;
`endif

   ahb_wr_capture_if bus ();

   ahb_wr_capture #(
      .ADDR_BASE (32'h4000_0000),
      .ADDR_MASK (32'hFFFF_0000),
      .FIFO_AW   (4)
   ) dut (
      .I_clk       (clk),
      .I_rst       (rst),
      .bus         (bus),
      .O_fifo_lvl  (lvl),
      .O_ovf       (ovf),
      .O_ovf_cnt   (ovf_cnt)
`ifdef AHB_CAP_TSTAMP_EN
      ,
      .O_wr_tstamp (tstamp)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [47:0] exp_q [$];

   typedef struct {
      logic [1:0]  htrans;
      logic        hwrite;
      logic [2:0]  hsize;
      logic [31:0] haddr;
      logic [31:0] hwdata;
      logic        hit;
      logic [15:0] off;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Compare any pop that the coming edge performs, then advance one cycle.
   // Inputs change and outputs are sampled on the falling edge.
   task automatic cycle();
      logic [47:0] e;
      if (bus.wr_vld && bus.wr_rdy) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_pop: got addr %0h data %0h expected no entry",
                     bus.wr_addr, bus.wr_data);
         end else begin
            e = exp_q.pop_front();
            check("pop_addr", {48'h0, bus.wr_addr}, {48'h0, e[47:32]});
            check("pop_data", {32'h0, bus.wr_data}, {32'h0, e[31:0]});
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic bus_idle();
      bus.htrans = 2'b00;
      bus.hwrite = 1'b0;
      bus.hsize  = 3'b000;
      bus.haddr  = 32'h0;
      bus.hready = 1'b1;
   endtask

   task automatic addr_phase(input logic [1:0] tr, input logic [31:0] a);
      bus.htrans = tr;
      bus.hwrite = 1'b1;
      bus.hsize  = 3'b010;
      bus.haddr  = a;
      bus.hready = 1'b1;
   endtask

   task automatic drain(input int budget);
      bus.wr_rdy = 1'b1;
      for (int k = 0; k < budget && exp_q.size() > 0; k++) cycle();
      check("drain_queue", exp_q.size(), 0);
      check("drain_lvl", {59'h0, lvl}, 0);
      check("drain_vld", bus.wr_vld, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
`ifdef AHB_CAP_TSTAMP_EN
      logic [31:0] t0;
`endif
      vecs[0] = '{2'b10, 1'b1, 3'b010, 32'h4000_0010, 32'hDEAD_BEEF, 1'b1, 16'h0010};
      vecs[1] = '{2'b11, 1'b1, 3'b010, 32'h4000_FFFC, 32'h1234_5678, 1'b1, 16'hFFFC};
      vecs[2] = '{2'b10, 1'b1, 3'b010, 32'h5000_0000, 32'h1111_1111, 1'b0, 16'h0000};
      vecs[3] = '{2'b10, 1'b0, 3'b010, 32'h4000_0000, 32'h2222_2222, 1'b0, 16'h0000};
      vecs[4] = '{2'b10, 1'b1, 3'b000, 32'h4000_0004, 32'h3333_3333, 1'b0, 16'h0000};
      vecs[5] = '{2'b10, 1'b1, 3'b001, 32'h4000_0008, 32'h4444_4444, 1'b0, 16'h0000};
      vecs[6] = '{2'b00, 1'b1, 3'b010, 32'h4000_000C, 32'h5555_5555, 1'b0, 16'h0000};
      vecs[7] = '{2'b01, 1'b1, 3'b010, 32'h4000_0014, 32'h6666_6666, 1'b0, 16'h0000};
      vecs[8] = '{2'b10, 1'b1, 3'b010, 32'h4000_1234, 32'hA5A5_5A5A, 1'b1, 16'h1234};

      rst        = 1'b1;
      bus.hwdata = 32'h0;
      bus.wr_rdy = 1'b0;
      bus_idle();
      @(negedge clk);
      cycle();
      cycle();
      check("rst_vld", bus.wr_vld, 0);
      check("rst_addr", {48'h0, bus.wr_addr}, 0);
      check("rst_data", {32'h0, bus.wr_data}, 0);
      check("rst_lvl", {59'h0, lvl}, 0);
      check("rst_ovf", ovf, 0);
      check("rst_ovf_cnt", {48'h0, ovf_cnt}, 0);
      rst        = 1'b0;
      bus.wr_rdy = 1'b1;
      cycle();

      // Single transfers: address phase, data phase, then one cycle to pop.
      for (int i = 0; i < 9; i++) begin
         bus.htrans = vecs[i].htrans;
         bus.hwrite = vecs[i].hwrite;
         bus.hsize  = vecs[i].hsize;
         bus.haddr  = vecs[i].haddr;
         bus.hready = 1'b1;
         bus.hwdata = 32'h0BAD_0BAD;
         cycle();
         bus_idle();
         bus.hwdata = vecs[i].hwdata;
         if (vecs[i].hit) exp_q.push_back({vecs[i].off, vecs[i].hwdata});
         cycle();
         check("vec_vld", bus.wr_vld, vecs[i].hit);
         bus.hwdata = 32'h0;
         cycle();
         check("vec_lvl", {59'h0, lvl}, 0);
      end
      check("vec_queue", exp_q.size(), 0);

      // 4-beat burst with two wait states on the second data phase.
      addr_phase(2'b10, 32'h4000_0020); bus.hwdata = 32'h0; cycle();
      addr_phase(2'b11, 32'h4000_0024); bus.hwdata = 32'hB000_0000;
      exp_q.push_back({16'h0020, 32'hB000_0000}); cycle();
      addr_phase(2'b11, 32'h4000_0028); bus.hready = 1'b0; bus.hwdata = 32'hEEEE_EEEE; cycle();
      bus.hwdata = 32'hFFFF_FFFF; cycle();
      bus.hready = 1'b1; bus.hwdata = 32'hB000_0001;
      exp_q.push_back({16'h0024, 32'hB000_0001}); cycle();
      addr_phase(2'b11, 32'h4000_002C); bus.hwdata = 32'hB000_0002;
      exp_q.push_back({16'h0028, 32'hB000_0002}); cycle();
      bus_idle(); bus.hwdata = 32'hB000_0003;
      exp_q.push_back({16'h002C, 32'hB000_0003}); cycle();
      bus.hwdata = 32'h0;
      drain(8);

      // Overflow: 18 captures with the consumer stalled.
      bus.wr_rdy = 1'b0;
      for (int i = 0; i <= 18; i++) begin
         if (i < 18) addr_phase((i == 0) ? 2'b10 : 2'b11, 32'h4000_0100 + 32'(4 * i));
         else bus_idle();
         if (i > 0) begin
            d = 32'hC000_0000 + 32'(i - 1);
            bus.hwdata = d;
            if (i - 1 < 16) exp_q.push_back({16'h0100 + 16'(4 * (i - 1)), d});
         end
         cycle();
      end
      check("ovf_lvl", {59'h0, lvl}, 16);
      check("ovf_flag", ovf, 1);
      check("ovf_cnt", {48'h0, ovf_cnt}, 2);
      for (int k = 0; k < 3; k++) begin
         check("stall_addr", {48'h0, bus.wr_addr}, {48'h0, exp_q[0][47:32]});
         check("stall_data", {32'h0, bus.wr_data}, {32'h0, exp_q[0][31:0]});
         cycle();
      end

      // Full FIFO with consumer ready: one push and one pop per cycle.
      for (int i = 0; i <= 4; i++) begin
         if (i < 4) addr_phase((i == 0) ? 2'b10 : 2'b11, 32'h4000_0200 + 32'(4 * i));
         else bus_idle();
         if (i > 0) begin
            d = 32'hD000_0000 + 32'(i - 1);
            bus.hwdata = d;
            bus.wr_rdy = 1'b1;
            exp_q.push_back({16'h0200 + 16'(4 * (i - 1)), d});
         end
         cycle();
         check("full_lvl", {59'h0, lvl}, 16);
      end
      bus.wr_rdy = 1'b0;
      bus.hwdata = 32'h0;
      cycle();
      check("full_lvl_end", {59'h0, lvl}, 16);
      check("full_ovf_cnt", {48'h0, ovf_cnt}, 2);
      drain(24);

      // Reset between address and data phase.
      bus.wr_rdy = 1'b0;
      addr_phase(2'b10, 32'h4000_0030); cycle();
      bus_idle(); bus.hwdata = 32'h7777_7777; cycle();
      check("pre_rst_lvl", {59'h0, lvl}, 1);
      addr_phase(2'b10, 32'h4000_0040); cycle();
      bus_idle(); rst = 1'b1; cycle();
      check("mid_rst_vld", bus.wr_vld, 0);
      check("mid_rst_addr", {48'h0, bus.wr_addr}, 0);
      check("mid_rst_data", {32'h0, bus.wr_data}, 0);
      check("mid_rst_lvl", {59'h0, lvl}, 0);
      check("mid_rst_ovf", ovf, 0);
      check("mid_rst_ovf_cnt", {48'h0, ovf_cnt}, 0);
      rst = 1'b0; bus.hwdata = 32'hCAFE_F00D; cycle();
      bus.hwdata = 32'h0; cycle();
      check("post_rst_vld", bus.wr_vld, 0);
      check("post_rst_lvl", {59'h0, lvl}, 0);
      bus.wr_rdy = 1'b1;
      addr_phase(2'b10, 32'h4000_0044); cycle();
      bus_idle(); bus.hwdata = 32'h0F0F_0F0F;
      exp_q.push_back({16'h0044, 32'h0F0F_0F0F}); cycle();
      bus.hwdata = 32'h0;
      drain(4);

`ifdef AHB_CAP_TSTAMP_EN
      // Two data phases exactly five cycles apart.
      bus.wr_rdy = 1'b0;
      addr_phase(2'b10, 32'h4000_0050); cycle();
      bus_idle(); bus.hwdata = 32'h5050_5050;
      exp_q.push_back({16'h0050, 32'h5050_5050}); cycle();
      bus.hwdata = 32'h0; cycle(); cycle(); cycle();
      addr_phase(2'b10, 32'h4000_0054); cycle();
      bus_idle(); bus.hwdata = 32'h5454_5454;
      exp_q.push_back({16'h0054, 32'h5454_5454}); cycle();
      bus.hwdata = 32'h0;
      t0 = tstamp;
      bus.wr_rdy = 1'b1;
      cycle();
      check("tstamp_delta", {32'h0, tstamp - t0}, 5);
      drain(4);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
